// File: rtl/alu_result_deserializer.sv
// alu_result_deserializer
// Receive-side decoder for the ALU serial response stream on `sout`.
// Rebuilds each response (4 DATA + 1 CTL, or a single CTL error packet)
// into one parallel transaction. It checks framing, packet-type order,
// the CRC3 of data responses and the parity of error responses.
// A good response gives a one-cycle res_valid pulse, and the result fields
// hold until the next good response. A broken response gives a one-cycle
// frame_err pulse and leaves the result fields unchanged.

module alu_result_deserializer #(
  parameter int GAP_MAX  = 64,
  parameter int PKT_BITS = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sout,
  output logic        res_valid,
  output logic        res_is_err,
  output logic [31:0] res_c,
  output logic [7:0]  res_ctl,
  output logic        res_chk_ok,
  output logic        frame_err
);

  // A packet is start + type + payload + stop, so the payload is PKT_BITS-3 bits.
  localparam int DATA_BITS = PKT_BITS - 3;
  localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);
  localparam int GAP_W = $clog2(GAP_MAX + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_MAX - 1);
  localparam logic [2:0] CTL_IDX = 3'd4;

  typedef enum logic [2:0] {
    S_RESYNC,
    S_IDLE,
    S_TYPE,
    S_DATA,
    S_STOP
  } state_t;

  state_t state, state_nxt;

  logic [2:0]       bit_cnt;
  logic             type_bit;    // 1 = CTL packet
  logic [7:0]       shreg;       // payload byte, MSB first
  logic [2:0]       pkt_idx;     // packet position within the current response
  logic [31:0]      data_sr;     // DATA bytes collected so far, first byte ends up as MSB
  logic [GAP_W-1:0] gap_cnt;

  logic pkt_done;     // a stop bit was sampled high
  logic stop_err;     // a stop bit was sampled low
  logic gap_expire;   // idle too long inside a response
  logic seq_err;      // packet type not allowed at this index
  logic err_done;     // single-CTL error response complete
  logic data_done;    // 4 DATA + CTL response complete
  logic discard;
  logic [2:0] crc_calc;

  // CRC3 with polynomial x^3+x+1 and init 0, bit 36 shifted in first.
  function automatic logic [2:0] crc3(input logic [36:0] v);
    logic [2:0] r;
    logic       fb;
    r = '0;
    for (int i = 36; i >= 0; i--) begin
      // NOTE: blocking assignments are correct here: each step of the loop
      // must see the CRC value that the previous step just produced.
      fb = v[i] ^ r[2];
      r  = {r[1], r[0] ^ fb, fb};
    end
    return r;
  endfunction

  // Bit-level state register; RESYNC after reset so that a low line is never taken as a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_RESYNC;
    else        state <= state_nxt;
  end

  // Next-state logic and per-packet events.
  always_comb begin
    // NOTE: every signal gets a default first. This stops a path that does
    // not assign it from inferring a latch.
    state_nxt  = state;
    pkt_done   = 1'b0;
    stop_err   = 1'b0;
    gap_expire = 1'b0;
    unique case (state)
      S_RESYNC: if (sout) state_nxt = S_IDLE;
      S_IDLE: begin
        if (!sout)
          state_nxt = S_TYPE;
        else if (pkt_idx != 3'd0 && gap_cnt == GAP_LAST)
          gap_expire = 1'b1;
      end
      S_TYPE: state_nxt = S_DATA;
      S_DATA: if (bit_cnt == DATA_LAST) state_nxt = S_STOP;
      S_STOP: begin
        if (sout) begin
          state_nxt = S_IDLE;
          pkt_done  = 1'b1;
        end else begin
          state_nxt = S_RESYNC;
          stop_err  = 1'b1;
        end
      end
      default: state_nxt = S_RESYNC;
    endcase
  end

  // Response-level classification of the packet that just finished.
  always_comb begin
    seq_err   = 1'b0;
    err_done  = 1'b0;
    data_done = 1'b0;
    if (pkt_done) begin
      if (pkt_idx == 3'd0)
        err_done = type_bit;
      else if (pkt_idx == CTL_IDX) begin
        data_done = type_bit;
        seq_err   = !type_bit;
      end else
        // A CTL at idx1..3 breaks the response. It does not start a new error response.
        seq_err = type_bit;
    end
    discard  = stop_err | seq_err | gap_expire;
    crc_calc = crc3({data_sr, 1'b0, shreg[6:3]});
  end

  // Per-packet shifter: capture the type bit, then shift in the payload MSB first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= '0;
      type_bit <= 1'b0;
      shreg    <= '0;
    end else begin
      if (state == S_TYPE) begin
        type_bit <= sout;
        bit_cnt  <= '0;
      end
      if (state == S_DATA) begin
        shreg   <= {shreg[6:0], sout};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

  // Response assembly: packet index, collected DATA bytes and the inter-packet gap timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_idx <= '0;
      data_sr <= '0;
      gap_cnt <= '0;
    end else begin
      if (discard || err_done || data_done)
        pkt_idx <= '0;
      else if (pkt_done)
        pkt_idx <= pkt_idx + 3'd1;

      // Only DATA packets reach data_sr. A new response starts at idx0 and
      // shifts in four fresh bytes, so stale bytes never reach res_c.
      if (pkt_done && !type_bit)
        data_sr <= {data_sr[23:0], shreg};

      if (discard || err_done || data_done || (state == S_IDLE && !sout))
        gap_cnt <= '0;
      else if (state == S_IDLE && pkt_idx != 3'd0)
        gap_cnt <= gap_cnt + 1'b1;
    end
  end

  // Result outputs: pulses for one cycle; the fields change only when a response completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid  <= 1'b0;
      res_is_err <= 1'b0;
      res_c      <= '0;
      res_ctl    <= '0;
      res_chk_ok <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments, so every
      // register updates from the values sampled at the same clock edge.
      res_valid <= err_done | data_done;
      frame_err <= discard;
      if (err_done) begin
        res_is_err <= 1'b1;
        res_c      <= '0;
        res_ctl    <= shreg;
        res_chk_ok <= ~^shreg;
      end else if (data_done) begin
        res_is_err <= 1'b0;
        res_c      <= data_sr;
        res_ctl    <= shreg;
        res_chk_ok <= (crc_calc == shreg[2:0]) && !shreg[7];
      end
    end
  end

endmodule
